pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator that replaces the single fixed-pattern PWM block with a runtime-configurable one. A shared period counter drives `CH` independent compare channels. Each channel has its own duty, phase offset and output polarity. Configuration is written through a simple write port into shadow registers, which are committed glitch-free at the period boundary. It sits next to the timer/LED blocks and feeds pin drivers directly.

## Interface
- `CH`, 4, number of PWM channels (1..16)
- `CW`, 16, counter/compare width in bits (4..32)
- `clk` input 1, sole clock, rising edge
- `rstn` input 1, asynchronous active-low reset
- `en` input 1, counter run enable
- `period` input CW, counter terminal value (counter runs 0..period), sampled through shadow
- `cfg_we` input 1, configuration write strobe, one write per cycle
- `cfg_ch` input max(1,$clog2(CH)), channel index for write; index >= CH ignored
- `cfg_duty` input CW, high-time in cycles
- `cfg_phase` input CW, start offset in cycles
- `cfg_pol` input 1, 1 = invert output
- `out` output CH, registered PWM outputs
- `sync` output 1, registered one-cycle pulse per period wrap

## Operation
- Registers: counter `cnt` (CW); active `per_a`; per channel active `duty_a`, `phase_a`, `pol_a`; shadow copies `per_s`, `duty_s`, `phase_s`, `pol_s`.
- `per_s` captures `period` every cycle. Channel shadows capture `cfg_*` on `cfg_we` for `cfg_ch`.
- Counter, `en`=1: if `cnt == per_a` then `cnt` <= 0 (wrap), else `cnt` <= `cnt`+1. `en`=0: `cnt` <= 0.
- Commit: on a wrap edge, or on any edge with `en`=0, all active registers load from their shadows. The commit takes the shadow value held before that edge. A `cfg_we` in the same cycle lands in the shadow and takes effect at the next commit.
- Per-channel compare, computed in CW+1 bits:
  - `rel` = `cnt` - `phase_a` if `cnt` >= `phase_a`, else `cnt` + `per_a` + 1 - `phase_a`.
  - `hi` = (`rel` < `duty_a`).
- Boundary rules:
  - `duty_a` = 0 gives always inactive.
  - `duty_a` > `per_a` gives always active.
  - `phase_a` > `per_a` is invalid and forces the inactive level.
- `out[i]` <= `hi` XOR `pol_a[i]` when `en`=1; `out[i]` <= `pol_a[i]` when `en`=0, i.e. the inactive level.
- `sync` <= `en` AND (`cnt == per_a`).
- `per_a` = 0: counter stays at 0, wraps every cycle, and `sync` is held high.

## Timing
- Reset (async assert, sync-free release): `cnt`=0, all active and shadow registers 0, `out`=0, `sync`=0.
- Output latency: `out` and `sync` at edge k+1 reflect `cnt` and active registers during cycle k. The output is therefore one cycle behind the counter value.
- Period length is `per_a`+1 cycles. Channel high-time is exactly min(`duty_a`, `per_a`+1) cycles per period, with no glitch at a commit.
- First cycle after `en` rises: `cnt`=0, and the active registers already hold the shadows from the disabled cycles.
- `en` dropping mid-period: `cnt` is 0 and `out` is at the inactive level on the next edge. There is no completion of the current period.
- `rstn` asserted mid-period: all state clears immediately, asynchronously. Configuration must be rewritten afterwards.
- A write to an out-of-range `cfg_ch` changes no state.

## Test plan
- Reset then `period`=15, ch0 duty=4 phase=4 pol=0, `en`=1 → `out[0]` high during the 4 cycles after counter values 4..7, `sync` pulses once per 16 cycles.
- ch1 duty=6 phase=13, `period`=15 → wrapped pulse: `out[1]` high for counter values 13,14,15,0,1,2 (one cycle late); ch2 duty=0 → constant 0; ch3 duty=20 → constant 1.
- Mid-period write of ch0 duty 4→8 and `period` 15→9 at `cnt`=6 → current period unchanged; the next period is 10 cycles with 8 high cycles; `cfg_we` on the exact wrap cycle takes effect one period later.
- `pol`=1 with duty=3 → inverted waveform; `en`=0 → `out` equals `pol` (1), `cnt` 0, `sync` 0.
- `period`=0, duty=1 → `sync` constantly 1 and `out` constantly active; phase=5 with `period`=3 → `out` inactive.
- Assert `rstn` low for 1 cycle mid-pulse → `out`, `sync` 0 immediately. After release with no writes and `en`=1, all outputs stay 0.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator with a shared period counter.
//
// A single counter runs 0..per_a and wraps. Each of CH channels compares
// the counter, shifted by its phase offset, against its duty and drives
// one output pin. Period and per-channel settings are written into shadow
// registers. They are copied into the active set only at a period wrap,
// or on every edge while the block is disabled. A running waveform
// therefore never sees a half-applied configuration.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   en         counter run enable (0 holds counter at 0, outputs inactive)
//   period     counter terminal value, sampled into shadow every cycle
//   cfg_we     channel configuration write strobe
//   cfg_ch     channel index for the write (index >= CH is ignored)
//   cfg_duty   high-time in cycles
//   cfg_phase  start offset in cycles
//   cfg_pol    1 = inverted output
//   out        registered PWM outputs, one per channel
//   sync       registered one-cycle pulse on every period wrap
module pwm_multi #(
    parameter int CH  = 4,
    parameter int CW  = 16,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [CW-1:0]  period,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_duty,
    input  logic [CW-1:0]  cfg_phase,
    input  logic           cfg_pol,
    output logic [CH-1:0]  out,
    output logic           sync
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_per_a;
    logic [CW-1:0] r_per_s;
    logic [CH-1:0] r_out;
    logic          r_sync;

    logic          w_wrap;
    logic          w_commit;
    logic [CH-1:0] w_out_next;

    // Wrap only matters while running; a disabled block commits every edge
    // so that the first enabled cycle already uses the latest settings.
    assign w_wrap   = (r_cnt == r_per_a);
    assign w_commit = ~en | w_wrap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_per_a <= '0;
            r_per_s <= '0;
            r_out   <= '0;
            r_sync  <= 1'b0;
        end else begin
            if (!en || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_per_a <= r_per_s;
            end
            r_per_s <= period;
            r_out   <= w_out_next;
            r_sync  <= en & w_wrap;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [CW-1:0] r_duty_a;
        logic [CW-1:0] r_phase_a;
        logic          r_pol_a;
        logic [CW-1:0] r_duty_s;
        logic [CW-1:0] r_phase_s;
        logic          r_pol_s;

        logic          w_sel;
        logic [CW:0]   w_cnt_x;
        logic [CW:0]   w_per_x;
        logic [CW:0]   w_ph_x;
        logic [CW:0]   w_rel;
        logic          w_hi;

        // An out-of-range index matches no channel, so it changes nothing.
        assign w_sel = cfg_we & (cfg_ch == CHW'(gi));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_duty_a  <= '0;
                r_phase_a <= '0;
                r_pol_a   <= 1'b0;
                r_duty_s  <= '0;
                r_phase_s <= '0;
                r_pol_s   <= 1'b0;
            end else begin
                // Commit takes the shadow as it was before this edge; a
                // write in the same cycle waits for the following commit.
                if (w_commit) begin
                    r_duty_a  <= r_duty_s;
                    r_phase_a <= r_phase_s;
                    r_pol_a   <= r_pol_s;
                end
                if (w_sel) begin
                    r_duty_s  <= cfg_duty;
                    r_phase_s <= cfg_phase;
                    r_pol_s   <= cfg_pol;
                end
            end
        end

        // Position inside the phase-shifted period, one extra bit so that
        // cnt + per + 1 cannot overflow before the subtraction.
        assign w_cnt_x = {1'b0, r_cnt};
        assign w_per_x = {1'b0, r_per_a};
        assign w_ph_x  = {1'b0, r_phase_a};
        assign w_rel   = (r_cnt >= r_phase_a) ? (w_cnt_x - w_ph_x)
                                              : (w_cnt_x + w_per_x + (CW+1)'(1) - w_ph_x);

        // duty 0 and duty > period fall out of the compare naturally; a
        // phase beyond the period is meaningless and parks the pin inactive.
        assign w_hi = (r_phase_a <= r_per_a) && (w_rel < {1'b0, r_duty_a});

        assign w_out_next[gi] = en ? (w_hi ^ r_pol_a) : r_pol_a;
    end

    assign out  = r_out;
    assign sync = r_sync;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [CW-1:0] period;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_duty;
    logic [CW-1:0] cfg_phase;
    logic          cfg_pol;
    logic [CH-1:0] out;
    logic          sync;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .period    (period),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_duty  (cfg_duty),
        .cfg_phase (cfg_phase),
        .cfg_pol   (cfg_pol),
        .out       (out),
        .sync      (sync)
    );

    typedef struct packed {
        logic [CH-1:0] o;
        logic          s;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: period position model using modular arithmetic.
    int m_cnt, m_per_a, m_per_s;
    int m_duty_a[CH], m_phase_a[CH], m_duty_s[CH], m_phase_s[CH];
    bit m_pol_a[CH], m_pol_s[CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per_a = 0; m_per_s = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty_a[i] = 0; m_phase_a[i] = 0; m_pol_a[i] = 0;
            m_duty_s[i] = 0; m_phase_s[i] = 0; m_pol_s[i] = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   pos;
        bit   hi;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            if (!en) begin
                e.o[i] = m_pol_a[i];
            end else begin
                hi = 0;
                if (m_phase_a[i] <= m_per_a) begin
                    pos = (m_cnt - m_phase_a[i] + m_per_a + 1) % (m_per_a + 1);
                    hi  = (pos < m_duty_a[i]);
                end
                e.o[i] = hi ^ m_pol_a[i];
            end
        end
        e.s = en && (m_cnt == m_per_a);
        return e;
    endfunction

    task automatic model_edge();
        bit wrap, commit;
        wrap   = en && (m_cnt == m_per_a);
        commit = !en || wrap;
        m_cnt  = commit ? 0 : m_cnt + 1;
        if (commit) begin
            m_per_a = m_per_s;
            for (int i = 0; i < CH; i++) begin
                m_duty_a[i] = m_duty_s[i]; m_phase_a[i] = m_phase_s[i]; m_pol_a[i] = m_pol_s[i];
            end
        end
        m_per_s = int'(period);
        if (cfg_we && int'(cfg_ch) < CH) begin
            m_duty_s[cfg_ch]  = int'(cfg_duty);
            m_phase_s[cfg_ch] = int'(cfg_phase);
            m_pol_s[cfg_ch]   = cfg_pol;
        end
    endtask

    // One clock: predict outputs from current inputs, advance model, then
    // compare the DUT against the oldest queued prediction.
    task automatic step(input string tag);
        exp_t e, got;
        e = rstn ? model_out() : '0;
        sb_q.push_back(e);
        if (!rstn) model_reset(); else model_edge();
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, ".out"}, 32'(out), 32'(got.o));
        chk({tag, ".sync"}, 32'(sync), 32'(got.s));
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic run_count(input int n, input string tag, output int hi0, output int syncs);
        hi0 = 0; syncs = 0;
        for (int k = 0; k < n; k++) begin
            step(tag);
            hi0   += int'(out[0]);
            syncs += int'(sync);
        end
    endtask

    task automatic cfg_write(input int ch, input int duty, input int phase, input bit pol);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_duty = CW'(duty); cfg_phase = CW'(phase); cfg_pol = pol;
        step("cfg");
        cfg_we = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input string tag);
        for (int k = 0; k < 100 && m_cnt != target; k++) step(tag);
        checks++;
        assert (m_cnt == target) else begin
            errors++;
            $error("FAIL %s.bound: counter %0d expected %0d", tag, m_cnt, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0, syncs;
        logic [CH-1:0] any_out;

        rstn = 1'b0; en = 1'b0; period = '0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_duty = '0; cfg_phase = '0; cfg_pol = 1'b0;
        model_reset();
        #1;
        chk("reset.out", 32'(out), 32'h0);
        chk("reset.sync", 32'(sync), 32'h0);
        run(2, "rst");
        rstn = 1'b1;

        // Basic, wrapped, zero and oversize duty channels.
        period = 16'd15;
        cfg_write(0, 4, 4, 0);
        cfg_write(1, 6, 13, 0);
        cfg_write(2, 0, 0, 0);
        cfg_write(3, 20, 0, 0);
        en = 1'b1;
        run(40, "base");
        run_count(16, "base", hi0, syncs);
        chk("base.hi_count", 32'(hi0), 32'd4);
        chk("base.sync_count", 32'(syncs), 32'd1);

        // Mid-period rewrite of duty and period.
        wait_cnt(6, "mid");
        period = 16'd9;
        cfg_write(0, 8, 4, 0);
        run(40, "mid");
        run_count(10, "mid", hi0, syncs);
        chk("mid.hi_count", 32'(hi0), 32'd8);
        chk("mid.sync_count", 32'(syncs), 32'd1);

        // Write landing on the wrap edge is delayed by one period.
        wait_cnt(9, "wrapw");
        cfg_write(0, 2, 4, 0);
        run_count(10, "wrapw", hi0, syncs);
        chk("wrapw.old_hi", 32'(hi0), 32'd8);
        run_count(10, "wrapw", hi0, syncs);
        chk("wrapw.new_hi", 32'(hi0), 32'd2);

        // Inverted polarity, then disable.
        cfg_write(0, 3, 0, 1);
        run(25, "pol");
        run_count(10, "pol", hi0, syncs);
        chk("pol.hi_count", 32'(hi0), 32'd7);
        en = 1'b0;
        run(2, "dis");
        chk("dis.out", 32'(out), 32'h1);
        chk("dis.sync", 32'(sync), 32'h0);

        // Zero period, then phase beyond period.
        period = 16'd0;
        cfg_write(0, 1, 0, 0);
        en = 1'b1;
        run(10, "per0");
        chk("per0.out", 32'(out), 32'h9);
        chk("per0.sync", 32'(sync), 32'h1);
        period = 16'd3;
        cfg_write(0, 1, 5, 0);
        run(10, "badph");
        chk("badph.out", 32'(out), 32'h8);

        // Asynchronous reset in the middle of a pulse.
        en = 1'b0;
        period = 16'd15;
        cfg_write(0, 8, 0, 0);
        step("rstpre");
        en = 1'b1;
        run(4, "rstpre");
        chk("rstpre.out0", 32'(out[0]), 32'h1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst.out", 32'(out), 32'h0);
        chk("arst.sync", 32'(sync), 32'h0);
        model_reset();
        step("arst");
        rstn = 1'b1;
        any_out = '0;
        for (int k = 0; k < 20; k++) begin
            step("post");
            any_out |= out;
        end
        chk("post.out_any", 32'(any_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
